// File: rtl/gf180mcu_ocd_io__supply_seq_if.sv
// rtl/gf180mcu_ocd_io__supply_seq_if.sv - supply detect inputs and staged reset outputs of the supply sequencer
//
// Signals:
//   dvdd_ok     raw IO supply detect from the DVDD pad (async, 1 = good)
//   vdd_ok      raw core supply detect from the VDD pad (async, 1 = good)
//   fault_clr   one-cycle pulse that clears the sticky fault flag
//   io_resetn   IO-ring reset release, active-low
//   core_resetn core reset release, active-low
//   pwr_good    full power-up sequence complete
//   fault       sticky brown-out flag
//   bo_count    saturating brown-out event count
// Modports: master = pad ring / supervisor side, slave = sequencer side.
interface gf180mcu_ocd_io__supply_seq_if #(
  parameter int BO_W = 8
);
  logic            dvdd_ok;
  logic            vdd_ok;
  logic            fault_clr;
  logic            io_resetn;
  logic            core_resetn;
  logic            pwr_good;
  logic            fault;
  logic [BO_W-1:0] bo_count;

  modport master (
    output dvdd_ok, vdd_ok, fault_clr,
    input  io_resetn, core_resetn, pwr_good, fault, bo_count
  );

  modport slave (
    input  dvdd_ok, vdd_ok, fault_clr,
    output io_resetn, core_resetn, pwr_good, fault, bo_count
  );
endinterface

// File: rtl/gf180mcu_ocd_io__supply_seq.sv
// rtl/gf180mcu_ocd_io__supply_seq.sv - supply-good sequencer with staged IO/core reset release and brown-out tracking
//
// Ports:
//   clk     sequencer clock
//   resetn  synchronous, active-low reset (aborts any sequence in progress)
//   bus     slave side of the supply sequencer interface: raw supply detects
//           and fault clear in; io_resetn, core_resetn, pwr_good, fault and
//           bo_count out, all registered.
module gf180mcu_ocd_io__supply_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 1024,
  parameter int STAGE_GAP   = 16,
  parameter int CNT_W       = 12,
  parameter int BO_W        = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  gf180mcu_ocd_io__supply_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    IO_REL,
    CORE_REL,
    RUN
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);

  logic [SYNC_STAGES-1:0] dvdd_sync;
  logic [SYNC_STAGES-1:0] vdd_sync;
  logic                   ok;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             io_q, io_d;
  logic             core_q, core_d;
  logic             pg_q, pg_d;
  logic             fault_q, fault_d;
  logic [BO_W-1:0]  bo_q, bo_d;
  logic             bo_event;

  assign ok = dvdd_sync[SYNC_STAGES-1] & vdd_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvdd_sync <= '0;
      vdd_sync  <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      io_q      <= 1'b0;
      core_q    <= 1'b0;
      pg_q      <= 1'b0;
      fault_q   <= 1'b0;
      bo_q      <= '0;
    end else begin
      dvdd_sync <= {dvdd_sync[SYNC_STAGES-2:0], bus.dvdd_ok};
      vdd_sync  <= {vdd_sync[SYNC_STAGES-2:0], bus.vdd_ok};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      io_q      <= io_d;
      core_q    <= core_d;
      pg_q      <= pg_d;
      fault_q   <= fault_d;
      bo_q      <= bo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bo_event = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ok) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        // A drop here is just input bounce, not a brown-out.
        if (!ok) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IO_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IO_REL, CORE_REL: begin
        // Loss of supply is checked before the stage timer so it always wins.
        if (!ok) begin
          bo_event = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = (state_q == IO_REL) ? CORE_REL : RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!ok) begin
          bo_event = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered, which keeps the release
    // ordering monotonic by construction.
    io_d   = (state_d == IO_REL) || (state_d == CORE_REL) || (state_d == RUN);
    core_d = (state_d == CORE_REL) || (state_d == RUN);
    pg_d   = (state_d == RUN);

    // A brown-out in the same cycle as a clear leaves the flag set.
    if (bo_event)          fault_d = 1'b1;
    else if (bus.fault_clr) fault_d = 1'b0;
    else                   fault_d = fault_q;

    if (bo_event && (bo_q != {BO_W{1'b1}})) bo_d = bo_q + BO_W'(1);
    else                                    bo_d = bo_q;
  end

  assign bus.io_resetn   = io_q;
  assign bus.core_resetn = core_q;
  assign bus.pwr_good    = pg_q;
  assign bus.fault       = fault_q;
  assign bus.bo_count    = bo_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io__supply_seq.sv
// tb/tb_gf180mcu_ocd_io__supply_seq.sv - self-checking bench for the supply sequencer
module tb_gf180mcu_ocd_io__supply_seq;
  localparam int SS   = 2;
  localparam int DEB  = 8;
  localparam int GAP  = 4;
  localparam int BO_W = 2;

  logic clk;
  logic resetn;
  int   errors = 0;
  int   checks = 0;
  int   rel    = 0;

  gf180mcu_ocd_io__supply_seq_if #(.BO_W(BO_W)) sif ();

  gf180mcu_ocd_io__supply_seq #(
    .SYNC_STAGES(SS),
    .DEB_CYCLES (DEB),
    .STAGE_GAP  (GAP),
    .CNT_W      (12),
    .BO_W       (BO_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: the sequence position is just the length of the current
  // unbroken run of "both supplies good" as seen after SS cycles of delay.
  bit hist[$];
  int streak;
  bit model_valid = 0;
  bit m_fault;
  int m_bo;
  bit m_io, m_core, m_pg;

  always @(posedge clk) begin
    bit seen, bo;
    if (!resetn) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(1'b0);
      streak = 0;
      m_fault = 0;
      m_bo = 0;
      model_valid = 1;
    end else if (model_valid) begin
      seen = hist.pop_front();
      hist.push_back(sif.dvdd_ok & sif.vdd_ok);
      bo = !seen && (streak >= 1 + DEB);
      streak = seen ? streak + 1 : 0;
      if (bo) m_fault = 1;
      else if (sif.fault_clr) m_fault = 0;
      if (bo && m_bo < (1 << BO_W) - 1) m_bo++;
    end
    m_io   = streak >= 1 + DEB;
    m_core = streak >= 1 + DEB + GAP;
    m_pg   = streak >= 1 + DEB + 2 * GAP;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("io_resetn", sif.io_resetn, m_io);
      chk("core_resetn", sif.core_resetn, m_core);
      chk("pwr_good", sif.pwr_good, m_pg);
      chk("fault", sif.fault, m_fault);
      chk("bo_count", sif.bo_count, m_bo);
      chk("order_core_io", sif.core_resetn & ~sif.io_resetn, 0);
      chk("order_pg_core", sif.pwr_good & ~sif.core_resetn, 0);
    end
  end

  // Inputs change 1 time unit after an edge; rel counts edges since a marker.
  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic do_reset();
    resetn = 0;
    sif.dvdd_ok = 0;
    sif.vdd_ok = 0;
    sif.fault_clr = 0;
    repeat (2) tick();
    resetn = 1;
  endtask

  task automatic power_to_run();
    sif.dvdd_ok = 1;
    sif.vdd_ok = 1;
    repeat (30) tick();
    chk("reach_pwr_good", sif.pwr_good, 1);
  endtask

  task automatic brownout(input bit with_clr);
    tick();
    rel = 0;
    sif.dvdd_ok = 0;
    repeat (2) tick();
    chk("bo_pg_still_high", sif.pwr_good, 1);
    if (with_clr) sif.fault_clr = 1;
    tick();
    sif.fault_clr = 0;
    chk("bo_outputs_low", {sif.io_resetn, sif.core_resetn, sif.pwr_good}, 0);
    chk("bo_fault_set", sif.fault, 1);
  endtask

  initial begin
    int io_e, core_e, pg_e, hold, r;
    bit saw_fault;
    resetn = 0;
    sif.dvdd_ok = 0;
    sif.vdd_ok = 0;
    sif.fault_clr = 0;

    // Reset state
    do_reset();
    chk("rst_outputs", {sif.io_resetn, sif.core_resetn, sif.pwr_good, sif.fault}, 0);
    chk("rst_bo_count", sif.bo_count, 0);

    // Power-up latency: release at edges 11, 15, 19
    tick();
    rel = 0;
    sif.dvdd_ok = 1;
    sif.vdd_ok = 1;
    io_e = -1; core_e = -1; pg_e = -1; saw_fault = 0;
    repeat (25) begin
      tick();
      if (sif.io_resetn && io_e < 0) io_e = rel;
      if (sif.core_resetn && core_e < 0) core_e = rel;
      if (sif.pwr_good && pg_e < 0) pg_e = rel;
      if (sif.fault) saw_fault = 1;
    end
    chk("pu_io_edge", io_e, 11);
    chk("pu_core_edge", core_e, 15);
    chk("pu_pg_edge", pg_e, 19);
    chk("pu_no_fault", saw_fault, 0);

    // Bounce mid-debounce: VDD low for 3 cycles restarts the full debounce
    do_reset();
    tick();
    rel = 0;
    sif.dvdd_ok = 1;
    sif.vdd_ok = 1;
    io_e = -1;
    repeat (30) begin
      tick();
      if (rel == 5) sif.vdd_ok = 0;
      if (rel == 8) sif.vdd_ok = 1;
      if (sif.io_resetn && io_e < 0) io_e = rel;
    end
    chk("bounce_io_edge", io_e, 19);
    chk("bounce_fault", sif.fault, 0);
    chk("bounce_bo_count", sif.bo_count, 0);

    // Brown-out in RUN, then re-sequence
    do_reset();
    power_to_run();
    brownout(0);
    chk("bo1_count", sif.bo_count, 1);
    power_to_run();
    chk("resequence_fault_sticky", sif.fault, 1);

    // Saturation and fault clear interaction
    do_reset();
    repeat (3) begin
      power_to_run();
      brownout(0);
    end
    chk("bo3_count", sif.bo_count, 3);
    sif.fault_clr = 1;
    tick();
    sif.fault_clr = 0;
    chk("clr_alone", sif.fault, 0);
    power_to_run();
    brownout(1);
    chk("bo_sat_count", sif.bo_count, 3);
    sif.fault_clr = 1;
    tick();
    sif.fault_clr = 0;
    chk("clr_after_bo", sif.fault, 0);

    // Reset while in CORE_REL
    tick();
    rel = 0;
    sif.dvdd_ok = 1;
    sif.vdd_ok = 1;
    repeat (16) tick();
    chk("core_rel_core", sif.core_resetn, 1);
    chk("core_rel_pg", sif.pwr_good, 0);
    resetn = 0;
    tick();
    resetn = 1;
    chk("midseq_rst_outputs", {sif.io_resetn, sif.core_resetn, sif.pwr_good, sif.fault}, 0);
    chk("midseq_rst_bo", sif.bo_count, 0);

    // Random toggling against the model
    hold = 0;
    for (int i = 0; i < 10000; i++) begin
      if (hold == 0) begin
        r = $urandom_range(0, 9);
        sif.dvdd_ok = (r != 0) && (r != 1);
        sif.vdd_ok  = (r != 0) && (r != 2);
        hold = (sif.dvdd_ok && sif.vdd_ok) ? $urandom_range(1, 60) : $urandom_range(1, 12);
      end else begin
        hold--;
      end
      sif.fault_clr = ($urandom_range(0, 15) == 0);
      resetn = ($urandom_range(0, 499) != 0);
      tick();
    end
    resetn = 1;
    sif.fault_clr = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
